// File: rtl/rhd_pkg.sv
// Shared definitions for the RHD MISO capture block: default sizes and
// the capture state encoding.
package rhd_pkg;

  localparam int DEF_NUM_MISO = 32;
  localparam int DEF_WORD_W   = 16;
  localparam int DEF_OFFSET_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } cap_state_e;

  // Counter width able to hold the value w itself (0..w).
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/rhd_miso_capture_if.sv
// Bundle of the capture block's strobe, data and result signals, with one
// modport for the SPI-master side and one for the capture side.
interface rhd_miso_capture_if #(
  parameter int NUM_MISO = rhd_pkg::DEF_NUM_MISO,
  parameter int WORD_W   = rhd_pkg::DEF_WORD_W,
  parameter int OFFSET_W = rhd_pkg::DEF_OFFSET_W
);
  import rhd_pkg::*;

  logic                         frame_start;
  logic                         rise_strobe;
  logic                         fall_strobe;
  logic                         ddr_en;
  logic [NUM_MISO-1:0]          miso;
  logic [NUM_MISO*OFFSET_W-1:0] offset;
  logic                         err_clr;
  logic [NUM_MISO*WORD_W-1:0]   word_a;
  logic [NUM_MISO*WORD_W-1:0]   word_b;
  logic                         word_valid;
  logic                         busy;
  logic [NUM_MISO-1:0]          late_err;

  modport master (
    output frame_start, rise_strobe, fall_strobe, ddr_en, miso, offset, err_clr,
    input  word_a, word_b, word_valid, busy, late_err
  );

  modport slave (
    input  frame_start, rise_strobe, fall_strobe, ddr_en, miso, offset, err_clr,
    output word_a, word_b, word_valid, busy, late_err
  );

endinterface

// File: rtl/rhd_miso_lane.sv
// One MISO line: picks its delayed strobes from the shared histories and
// shifts bits into the rising-edge (A) and falling-edge (B) words.
module rhd_miso_lane
  import rhd_pkg::*;
#(
  parameter int WORD_W   = DEF_WORD_W,
  parameter int OFFSET_W = DEF_OFFSET_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       frame_start,
  input  logic                       capture_en,
  input  logic                       ddr,
  input  logic [(1<<OFFSET_W)-1:0]   taps_r,
  input  logic [(1<<OFFSET_W)-1:0]   taps_f,
  input  logic                       miso_bit,
  input  logic [OFFSET_W-1:0]        offset_in,
  output logic [WORD_W-1:0]          sr_a_next,
  output logic [WORD_W-1:0]          sr_b_next,
  output logic                       complete_now,
  output logic                       complete_next
);

  localparam int CNT_W = cnt_width(WORD_W);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(WORD_W);

  logic [OFFSET_W-1:0] offset_q, offset_d;
  logic [WORD_W-1:0]   sr_a_q, sr_a_d;
  logic [WORD_W-1:0]   sr_b_q, sr_b_d;
  logic [CNT_W-1:0]    cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0]    cnt_b_q, cnt_b_d;

  always_comb begin
    offset_d = offset_q;
    sr_a_d   = sr_a_q;
    sr_b_d   = sr_b_q;
    cnt_a_d  = cnt_a_q;
    cnt_b_d  = cnt_b_q;
    if (frame_start) begin
      offset_d = offset_in;
      sr_a_d   = '0;
      sr_b_d   = '0;
      cnt_a_d  = '0;
      cnt_b_d  = '0;
    end else if (capture_en) begin
      // Strobes beyond a full word are dropped so extra SCLK edges are harmless.
      if (taps_r[offset_q] && (cnt_a_q != FULL)) begin
        sr_a_d  = {sr_a_q[WORD_W-2:0], miso_bit};
        cnt_a_d = cnt_a_q + CNT_W'(1);
      end
      if (ddr && taps_f[offset_q] && (cnt_b_q != FULL)) begin
        sr_b_d  = {sr_b_q[WORD_W-2:0], miso_bit};
        cnt_b_d = cnt_b_q + CNT_W'(1);
      end
    end
  end

  assign sr_a_next     = sr_a_d;
  assign sr_b_next     = sr_b_d;
  assign complete_now  = (cnt_a_q == FULL) && (!ddr || (cnt_b_q == FULL));
  assign complete_next = (cnt_a_d == FULL) && (!ddr || (cnt_b_d == FULL));

  always_ff @(posedge clk) begin
    if (rst) begin
      offset_q <= '0;
      sr_a_q   <= '0;
      sr_b_q   <= '0;
      cnt_a_q  <= '0;
      cnt_b_q  <= '0;
    end else begin
      offset_q <= offset_d;
      sr_a_q   <= sr_a_d;
      sr_b_q   <= sr_b_d;
      cnt_a_q  <= cnt_a_d;
      cnt_b_q  <= cnt_b_d;
    end
  end

endmodule

// File: rtl/rhd_miso_capture.sv
// Captures one SPI word per MISO line (two in DDR mode), each line sampled on
// its own delayed copy of the SCLK edge strobes to absorb cable/headstage delay.
module rhd_miso_capture
  import rhd_pkg::*;
#(
  parameter int NUM_MISO = DEF_NUM_MISO,
  parameter int WORD_W   = DEF_WORD_W,
  parameter int OFFSET_W = DEF_OFFSET_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         frame_start,
  input  logic                         rise_strobe,
  input  logic                         fall_strobe,
  input  logic                         ddr_en,
  input  logic [NUM_MISO-1:0]          miso,
  input  logic [NUM_MISO*OFFSET_W-1:0] offset,
  input  logic                         err_clr,
  output logic [NUM_MISO*WORD_W-1:0]   word_a,
  output logic [NUM_MISO*WORD_W-1:0]   word_b,
  output logic                         word_valid,
  output logic                         busy,
  output logic [NUM_MISO-1:0]          late_err
);

  localparam int DEPTH = 1 << OFFSET_W;

  // Tap k is the strobe delayed k cycles; tap 0 is the live strobe.
  logic [DEPTH-1:0] taps_r, taps_f;
  logic [DEPTH-2:0] hist_r_q, hist_r_d;
  logic [DEPTH-2:0] hist_f_q, hist_f_d;

  assign taps_r = {hist_r_q, rise_strobe};
  assign taps_f = {hist_f_q, fall_strobe};

  cap_state_e                 state_q, state_d;
  logic                       busy_q, busy_d;
  logic                       word_valid_q, word_valid_d;
  logic                       ddr_q, ddr_d;
  logic [NUM_MISO*WORD_W-1:0] word_a_q, word_a_d;
  logic [NUM_MISO*WORD_W-1:0] word_b_q, word_b_d;
  logic [NUM_MISO-1:0]        late_err_q, late_err_d;

  logic                       capture_en;
  logic [NUM_MISO*WORD_W-1:0] sr_a_next, sr_b_next;
  logic [NUM_MISO-1:0]        complete_now, complete_next;

  assign capture_en = (state_q == CAPTURE);

  generate
    for (genvar gi = 0; gi < NUM_MISO; gi++) begin : g_lane
      rhd_miso_lane #(
        .WORD_W   (WORD_W),
        .OFFSET_W (OFFSET_W)
      ) u_lane (
        .clk           (clk),
        .rst           (rst),
        .frame_start   (frame_start),
        .capture_en    (capture_en),
        .ddr           (ddr_q),
        .taps_r        (taps_r),
        .taps_f        (taps_f),
        .miso_bit      (miso[gi]),
        .offset_in     (offset[gi*OFFSET_W +: OFFSET_W]),
        .sr_a_next     (sr_a_next[gi*WORD_W +: WORD_W]),
        .sr_b_next     (sr_b_next[gi*WORD_W +: WORD_W]),
        .complete_now  (complete_now[gi]),
        .complete_next (complete_next[gi])
      );
    end
  endgenerate

  always_comb begin
    hist_r_d     = taps_r[DEPTH-2:0];
    hist_f_d     = taps_f[DEPTH-2:0];
    state_d      = state_q;
    busy_d       = busy_q;
    word_valid_d = 1'b0;
    ddr_d        = ddr_q;
    word_a_d     = word_a_q;
    word_b_d     = word_b_q;
    // A new error set in the same cycle wins over err_clr.
    late_err_d   = err_clr ? '0 : late_err_q;
    unique case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d = CAPTURE;
          busy_d  = 1'b1;
          ddr_d   = ddr_en;
        end
      end
      CAPTURE: begin
        if (frame_start) begin
          late_err_d = late_err_d | ~complete_now;
          ddr_d      = ddr_en;
        end else if (&complete_next) begin
          // Decided from next-state counts so word_valid lands one cycle
          // after the final sample, straight from a flop.
          state_d      = DONE;
          busy_d       = 1'b0;
          word_valid_d = 1'b1;
          word_a_d     = sr_a_next;
          word_b_d     = sr_b_next;
        end
      end
      DONE: begin
        if (frame_start) begin
          state_d = CAPTURE;
          busy_d  = 1'b1;
          ddr_d   = ddr_en;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_r_q     <= '0;
      hist_f_q     <= '0;
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      word_valid_q <= 1'b0;
      ddr_q        <= 1'b0;
      word_a_q     <= '0;
      word_b_q     <= '0;
      late_err_q   <= '0;
    end else begin
      hist_r_q     <= hist_r_d;
      hist_f_q     <= hist_f_d;
      state_q      <= state_d;
      busy_q       <= busy_d;
      word_valid_q <= word_valid_d;
      ddr_q        <= ddr_d;
      word_a_q     <= word_a_d;
      word_b_q     <= word_b_d;
      late_err_q   <= late_err_d;
    end
  end

  assign word_a     = word_a_q;
  assign word_b     = word_b_q;
  assign word_valid = word_valid_q;
  assign busy       = busy_q;
  assign late_err   = late_err_q;

endmodule

// File: tb/tb_rhd_miso_capture.sv
// Bench for rhd_miso_capture: per-cycle stimulus tables built from slave data
// words and offsets, with expected words and word_valid timing from the model.
module tb_rhd_miso_capture;
  import rhd_pkg::*;

  localparam int NM   = 32;
  localparam int WW   = 16;
  localparam int OW   = 8;
  localparam int MAXC = 1400;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rhd_miso_capture_if #(.NUM_MISO(NM), .WORD_W(WW), .OFFSET_W(OW)) bus ();

  rhd_miso_capture #(.NUM_MISO(NM), .WORD_W(WW), .OFFSET_W(OW)) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (bus.frame_start),
    .rise_strobe (bus.rise_strobe),
    .fall_strobe (bus.fall_strobe),
    .ddr_en      (bus.ddr_en),
    .miso        (bus.miso),
    .offset      (bus.offset),
    .err_clr     (bus.err_clr),
    .word_a      (bus.word_a),
    .word_b      (bus.word_b),
    .word_valid  (bus.word_valid),
    .busy        (bus.busy),
    .late_err    (bus.late_err)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Per-cycle stimulus tables.
  logic           st_fs   [MAXC];
  logic           st_r    [MAXC];
  logic           st_f    [MAXC];
  logic           st_ddr  [MAXC];
  logic           st_rst  [MAXC];
  logic           st_clr  [MAXC];
  logic [NM-1:0]  st_miso [MAXC];
  logic [NM*OW-1:0] st_off [MAXC];

  // Slave model: per-line offset and the words each slave drives.
  int          ln_off [NM];
  logic [WW-1:0] ln_a [NM];
  logic [WW-1:0] ln_b [NM];
  logic [WW-1:0] exp_a [NM];
  logic [WW-1:0] exp_b [NM];

  int   snap_cyc = -1;
  logic snap_busy;
  logic snap_wa_or;
  logic [NM-1:0] snap_late;

  // Non-sample cycles carry random miso, and offset/ddr_en are random except
  // on frame_start, so only the latched values may matter.
  task automatic clear_stim();
    for (int c = 0; c < MAXC; c++) begin
      st_fs[c]   = 1'b0;
      st_r[c]    = 1'b0;
      st_f[c]    = 1'b0;
      st_rst[c]  = 1'b0;
      st_clr[c]  = 1'b0;
      st_ddr[c]  = 1'($urandom_range(0, 1));
      st_miso[c] = $urandom;
      for (int j = 0; j < NM*OW/32; j++) st_off[c][j*32 +: 32] = $urandom;
    end
  endtask

  // Frame starting at cycle base; last = latest cycle at which any line's
  // 16th required (delayed) strobe is seen.
  task automatic build(input int base, input bit ddr, input int nstr, input int per,
                       output int last);
    int tr, tf, s;
    last = 0;
    st_fs[base]  = 1'b1;
    st_ddr[base] = ddr;
    for (int i = 0; i < NM; i++) st_off[base][i*OW +: OW] = OW'(ln_off[i]);
    for (int k = 0; k < nstr; k++) begin
      tr = base + 2 + k*per;
      tf = tr + per/2;
      st_r[tr] = 1'b1;
      st_f[tf] = 1'b1;
      if (k < WW) begin
        for (int i = 0; i < NM; i++) begin
          st_miso[tr + ln_off[i]][i] = ln_a[i][WW-1-k];
          if (ddr) st_miso[tf + ln_off[i]][i] = ln_b[i][WW-1-k];
          if (k == WW-1) begin
            s = ddr ? (tf + ln_off[i]) : (tr + ln_off[i]);
            if (s > last) last = s;
          end
        end
      end
    end
  endtask

  task automatic play(input string tag, input int len, input int lo, input int hi,
                      output int nvalid, output int vcyc);
    int bmis = 0;
    nvalid = 0;
    vcyc   = -1;
    for (int c = 0; c < len; c++) begin
      @(posedge clk);
      #1;
      rst             = st_rst[c];
      bus.frame_start = st_fs[c];
      bus.rise_strobe = st_r[c];
      bus.fall_strobe = st_f[c];
      bus.ddr_en      = st_ddr[c];
      bus.miso        = st_miso[c];
      bus.offset      = st_off[c];
      bus.err_clr     = st_clr[c];
      @(negedge clk);
      if (bus.word_valid === 1'b1) begin
        nvalid++;
        vcyc = c;
      end
      if (bus.busy !== ((c >= lo) && (c <= hi))) bmis++;
      if (c == snap_cyc) begin
        snap_busy  = bus.busy;
        snap_wa_or = |bus.word_a;
        snap_late  = bus.late_err;
      end
    end
    chk({tag, "_busy_window_mismatches"}, 64'(bmis), 64'd0);
  endtask

  task automatic check_frame(input string tag, input int last, input int nv, input int vc,
                             input logic [NM-1:0] exp_late);
    chk({tag, "_valid_count"}, 64'(nv), 64'd1);
    chk({tag, "_valid_cycle"}, 64'(vc), 64'(last + 1));
    for (int i = 0; i < NM; i++) begin
      chk($sformatf("%s_word_a[%0d]", tag, i), 64'(bus.word_a[i*WW +: WW]), 64'(exp_a[i]));
      chk($sformatf("%s_word_b[%0d]", tag, i), 64'(bus.word_b[i*WW +: WW]), 64'(exp_b[i]));
    end
    chk({tag, "_late_err"}, 64'(bus.late_err), 64'(exp_late));
  endtask

  typedef struct {
    bit          ddr;
    int          nstr;
    int          per;
    int          off0;
    int          off1;
    int          offr;
    logic [15:0] rise_w;
    logic [15:0] fall_w;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
  } vec_t;

  vec_t  tbl [5];
  string tbl_name [5];

  task automatic set_vec(input int n, input string name, input bit ddr, input int nstr,
                         input int per, input int off0, input int off1, input int offr,
                         input logic [15:0] rw, input logic [15:0] fw,
                         input logic [15:0] ea, input logic [15:0] eb);
    tbl_name[n]    = name;
    tbl[n].ddr     = ddr;
    tbl[n].nstr    = nstr;
    tbl[n].per     = per;
    tbl[n].off0    = off0;
    tbl[n].off1    = off1;
    tbl[n].offr    = offr;
    tbl[n].rise_w  = rw;
    tbl[n].fall_w  = fw;
    tbl[n].exp_a   = ea;
    tbl[n].exp_b   = eb;
  endtask

  initial begin
    int last, nv, vc, dummy;
    bit ddr;

    set_vec(0, "sdr_off0",       0, 16, 4, 0, 0,   0, 16'hA5C3, 16'h0F0F, 16'hA5C3, 16'h0000);
    set_vec(1, "off5_off200",    0, 16, 4, 5, 200, 0, 16'h9E37, 16'h0000, 16'h9E37, 16'h0000);
    set_vec(2, "ddr_1234_fedc",  1, 16, 4, 0, 0,   0, 16'h1234, 16'hFEDC, 16'h1234, 16'hFEDC);
    set_vec(3, "extra_strobes",  0, 18, 4, 0, 0,   0, 16'hC0DE, 16'h5555, 16'hC0DE, 16'h0000);
    set_vec(4, "ddr_extra_offs", 1, 19, 2, 3, 17,  9, 16'h8001, 16'h7FFE, 16'h8001, 16'h7FFE);

    rst             = 1'b1;
    bus.frame_start = 1'b0;
    bus.rise_strobe = 1'b0;
    bus.fall_strobe = 1'b0;
    bus.ddr_en      = 1'b0;
    bus.miso        = '0;
    bus.offset      = '0;
    bus.err_clr     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_word_a",     64'(|bus.word_a), 64'd0);
    chk("reset_word_b",     64'(|bus.word_b), 64'd0);
    chk("reset_word_valid", 64'(bus.word_valid), 64'd0);
    chk("reset_busy",       64'(bus.busy), 64'd0);
    chk("reset_late_err",   64'(bus.late_err), 64'd0);

    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < NM; i++) begin
        ln_off[i] = (i == 0) ? tbl[v].off0 : (i == 1) ? tbl[v].off1 : tbl[v].offr;
        ln_a[i]   = tbl[v].rise_w;
        ln_b[i]   = tbl[v].fall_w;
        exp_a[i]  = tbl[v].exp_a;
        exp_b[i]  = tbl[v].exp_b;
      end
      clear_stim();
      build(0, tbl[v].ddr, tbl[v].nstr, tbl[v].per, last);
      play(tbl_name[v], last + 260, 1, last, nv, vc);
      check_frame(tbl_name[v], last, nv, vc, '0);
      $display("vector %s: valid_cycle=%0d expected=%0d", tbl_name[v], vc, last + 1);
    end

    for (int f = 0; f < 6; f++) begin
      int nstr, per;
      ddr  = 1'($urandom_range(0, 1));
      nstr = $urandom_range(16, 19);
      per  = $urandom_range(2, 6);
      for (int i = 0; i < NM; i++) begin
        ln_off[i] = $urandom_range(0, 255);
        ln_a[i]   = 16'($urandom);
        ln_b[i]   = 16'($urandom);
        exp_a[i]  = ln_a[i];
        exp_b[i]  = ddr ? ln_b[i] : 16'h0000;
      end
      clear_stim();
      build(0, ddr, nstr, per, last);
      play($sformatf("rand%0d", f), last + 260, 1, last, nv, vc);
      check_frame($sformatf("rand%0d", f), last, nv, vc, '0);
      $display("random frame %0d: ddr=%0d strobes=%0d period=%0d valid_cycle=%0d", f, ddr, nstr, per, vc);
    end

    // Abort after 10 strobes, then a full frame.
    for (int i = 0; i < NM; i++) begin
      ln_off[i] = 0;
      ln_a[i]   = 16'h5A5A;
      ln_b[i]   = 16'h0000;
      exp_a[i]  = 16'h5A5A;
      exp_b[i]  = 16'h0000;
    end
    clear_stim();
    build(0, 1'b0, 10, 4, dummy);
    build(50, 1'b0, 16, 4, last);
    play("abort_restart", last + 260, 1, last, nv, vc);
    check_frame("abort_restart", last, nv, vc, '1);
    $display("abort/restart: valid_cycle=%0d late_err=%0h", vc, bus.late_err);

    clear_stim();
    st_clr[1] = 1'b1;
    play("err_clr", 4, 1, 0, nv, vc);
    chk("err_clr_late_err", 64'(bus.late_err), 64'd0);
    chk("err_clr_no_valid", 64'(nv), 64'd0);
    $display("err_clr: late_err=%0h", bus.late_err);

    // Abort coinciding with err_clr: the new error must stick.
    clear_stim();
    build(0, 1'b0, 4, 4, dummy);
    build(30, 1'b0, 16, 4, last);
    st_clr[30] = 1'b1;
    play("clr_vs_set", last + 260, 1, last, nv, vc);
    check_frame("clr_vs_set", last, nv, vc, '1);
    $display("err_clr vs set: late_err=%0h", bus.late_err);

    // Reset after 8 strobes (rise at cycles 2..30, reset in cycle 34).
    clear_stim();
    build(0, 1'b0, 16, 4, dummy);
    st_rst[34] = 1'b1;
    snap_cyc = 35;
    play("mid_reset", 300, 1, 34, nv, vc);
    snap_cyc = -1;
    chk("mid_reset_busy",     64'(snap_busy), 64'd0);
    chk("mid_reset_word_a",   64'(snap_wa_or), 64'd0);
    chk("mid_reset_late_err", 64'(snap_late), 64'd0);
    chk("mid_reset_no_valid", 64'(nv), 64'd0);
    $display("mid-frame reset: busy=%0d word_a_nonzero=%0d late_err=%0h", snap_busy, snap_wa_or, snap_late);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
